id_emit: RTL and testbench

- Transmitter counterpart of the identifier recogniser. Takes a (letter, unsigned number) request and emits the ASCII identifier one character per cycle on a valid/ready byte stream.
- Emission order: the letter, then the decimal digits MSB-first with leading zeros suppressed, then one separator character.
- Feeds the recogniser and the test-stream paths in the ID-check datapath.

---
 rtl/id_pkg.sv | 23 ++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/id_emit.sv | 129 ++++++++++++
 tb/tb_id_emit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared definitions for the identifier emitter and recogniser: FSM states,
// ASCII constants and the letter classifier.
package id_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CONV   = 3'd1,
    EMIT_L = 3'd2,
    EMIT_D = 3'd3,
    EMIT_S = 3'd4
  } state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LZ = 8'h7A;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CH_A) && (c <= CH_Z)) || ((c >= CH_LA) && (c <= CH_LZ));
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one adjust-and-shift step per clock, NUM_W steps
// after start. done is high during the cycle whose closing edge is the last shift.
module bin2bcd_seq #(
  parameter int NUM_W  = 14,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(NUM_W + 1);

  logic [BW-1:0]    bcd_r;
  logic [BW-1:0]    adj;
  logic [NUM_W-1:0] bin_r;
  logic [CW-1:0]    cnt;

  // Add 3 to every nibble that is 5 or more before the shift doubles it.
  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcd_r <= '0;
      bin_r <= '0;
      cnt   <= '0;
    end else if (start) begin
      bcd_r <= '0;
      bin_r <= bin;
      cnt   <= CW'(NUM_W);
    end else if (cnt != '0) begin
      bcd_r <= {adj[BW-2:0], bin_r[NUM_W-1]};
      bin_r <= {bin_r[NUM_W-2:0], 1'b0};
      cnt   <= cnt - 1'b1;
    end
  end

  assign done = (cnt == CW'(1));
  assign bcd  = bcd_r;

endmodule

// File: rtl/id_emit.sv
// Emits "<letter><decimal digits><SEP>" for a (letter, number) request, one
// character per cycle, leading zeros suppressed.
module id_emit
  import id_pkg::*;
#(
  parameter int         NUM_W  = 14,
  parameter int         DIGITS = 5,
  parameter logic [7:0] SEP    = 8'h20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_letter,
  input  logic [NUM_W-1:0] in_num,
  output logic [7:0]       char,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             err
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a
  // raised valid and its payload hold until that edge (reset excepted).

  localparam int BW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state;
  logic [7:0]      letter;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   nd_m1;
  logic [BW-1:0]   bcd;
  logic [BW-1:0]   top_sh;
  logic [BW-1:0]   next_sh;
  logic [3:0]      dig_top;
  logic [3:0]      dig_next;
  logic            conv_done;
  logic            start;

  assign start = (state == IDLE) && in_valid && is_letter(in_letter);

  bin2bcd_seq #(
    .NUM_W  (NUM_W),
    .DIGITS (DIGITS)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (in_num),
    .bcd   (bcd),
    .done  (conv_done)
  );

  // The converter holds its result after done, so the digit count and the
  // digit selects can be derived combinationally from the held value.
  always_comb begin
    nd_m1 = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0)
        nd_m1 = IW'(i);
    end
    top_sh   = bcd >> (4 * nd_m1);
    next_sh  = bcd >> (4 * (idx - 1'b1));
    dig_top  = top_sh[3:0];
    dig_next = next_sh[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      letter     <= 8'h00;
      idx        <= '0;
      char       <= 8'h00;
      char_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_letter(in_letter)) begin
              letter <= in_letter;
              state  <= CONV;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CONV: begin
          if (conv_done) begin
            char       <= letter;
            char_valid <= 1'b1;
            state      <= EMIT_L;
          end
        end
        EMIT_L: begin
          if (char_ready) begin
            idx   <= nd_m1;
            char  <= CH_0 + {4'h0, dig_top};
            state <= EMIT_D;
          end
        end
        EMIT_D: begin
          if (char_ready) begin
            if (idx == '0) begin
              char  <= SEP;
              state <= EMIT_S;
            end else begin
              idx  <= idx - 1'b1;
              char <= CH_0 + {4'h0, dig_next};
            end
          end
        end
        EMIT_S: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_id_emit.sv
// Directed bench for id_emit: hand-computed character streams checked through
// an expected-byte queue with immediate assertions.
module tb_id_emit;

  localparam int NUM_W = 14;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_letter;
  logic [NUM_W-1:0] in_num;
  logic [7:0]       char;
  logic             char_valid;
  logic             char_ready;
  logic             busy;
  logic             err;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  id_emit #(.NUM_W(NUM_W), .DIGITS(5), .SEP(8'h20)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_letter  (in_letter),
    .in_num     (in_num),
    .char       (char),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .err        (err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: present one request for a single accept edge
  task automatic send(input logic [7:0] l, input logic [NUM_W-1:0] n);
    in_valid  = 1'b1;
    in_letter = l;
    in_num    = n;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  // cycles from the accept edge until char_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!char_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 5) begin
        chk("conv_in_ready", in_ready, 0);
        chk("conv_busy", busy, 1);
      end
    end
  endtask

  // scoreboard: drain exp_q with char_ready following a 4-cycle pattern
  task automatic drain(input logic [3:0] pat);
    int ph = 0;
    int guard = 0;
    logic stalled;
    logic [7:0] held;
    logic [7:0] e;
    while (exp_q.size() > 0 && guard < 200) begin
      char_ready = pat[3 - (ph % 4)];
      ph++;
      chk("stream_valid", char_valid, 1);
      stalled = 1'b0;
      held = char;
      if (char_valid && char_ready) begin
        e = exp_q.pop_front();
        chk("stream_char", char, e);
      end else if (char_valid) begin
        stalled = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
      if (stalled) chk("stall_hold", {char_valid, char}, {1'b1, held});
    end
    chk("stream_left", exp_q.size(), 0);
    chk("end_valid", char_valid, 0);
    chk("end_in_ready", in_ready, 1);
    char_ready = 1'b1;
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input int n);
    logic [7:0] v[7];
    v = '{b0, b1, b2, b3, b4, b5, b6};
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_letter = 8'h00; in_num = '0; char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char", char, 8'h00);
    chk("rst_valid", char_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 'A', 123
    send(8'h41, 14'd123);
    wait_valid(lat);
    chk("latency_A", lat, 14);
    push_bytes(8'h41, 8'h31, 8'h32, 8'h33, 8'h20, 8'h00, 8'h00, 5);
    drain(4'b1111);

    // 'z', 0
    send(8'h7A, 14'd0);
    wait_valid(lat);
    chk("latency_z", lat, 14);
    push_bytes(8'h7A, 8'h30, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    drain(4'b1111);

    // 'Q', 16383
    send(8'h51, 14'd16383);
    wait_valid(lat);
    chk("latency_Q", lat, 14);
    push_bytes(8'h51, 8'h31, 8'h36, 8'h33, 8'h38, 8'h33, 8'h20, 7);
    drain(4'b1111);

    // 'b', 1005 with stalls
    send(8'h62, 14'd1005);
    wait_valid(lat);
    chk("latency_b", lat, 14);
    push_bytes(8'h62, 8'h31, 8'h30, 8'h30, 8'h35, 8'h20, 8'h00, 6);
    drain(4'b1001);

    // illegal letter '5'
    send(8'h35, 14'd42);
    chk("err_pulse", err, 1);
    chk("err_valid", char_valid, 0);
    chk("err_in_ready", in_ready, 1);
    chk("err_busy", busy, 0);
    @(posedge clk); #1;
    chk("err_clear", err, 0);
    chk("err_valid2", char_valid, 0);

    // following legal request 'k', 42
    send(8'h6B, 14'd42);
    wait_valid(lat);
    chk("latency_k", lat, 14);
    push_bytes(8'h6B, 8'h34, 8'h32, 8'h20, 8'h00, 8'h00, 8'h00, 4);
    drain(4'b1111);

    // reset while the second digit of 'D', 456 is valid
    send(8'h44, 14'd456);
    wait_valid(lat);
    chk("latency_D", lat, 14);
    chk("rstm_letter", char, 8'h44);
    @(posedge clk); #1;
    chk("rstm_dig1", char, 8'h34);
    @(posedge clk); #1;
    chk("rstm_dig2", char, 8'h35);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstm_valid", char_valid, 0);
    chk("rstm_char", char, 8'h00);
    chk("rstm_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rstm_quiet", char_valid, 0);

    // 'C', 7 after the abandoned request
    send(8'h43, 14'd7);
    wait_valid(lat);
    chk("latency_C", lat, 14);
    push_bytes(8'h43, 8'h37, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    drain(4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
